// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, handler vector and PRId value.
// The optional BadVAddr register is enabled by the CP0_BADVADDR_EN macro.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] PRID         = 32'h0000_2020;

  // Return address for a trap: a delay-slot instruction restarts at its branch.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    logic [31:0] raw;
    raw = bd ? (pc - 32'd4) : pc;
    return raw & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// Pipeline-side signal bundle for CP0; master is the pipeline, slave is CP0.
// BadAddr_M exists only when CP0_BADVADDR_EN is defined.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] PC_M;
  logic        BD_M;
  logic [4:0]  ExcCode_M;
  logic        EXLClr;
  logic [5:0]  HWInt;
`ifdef CP0_BADVADDR_EN
  logic [31:0] BadAddr_M;
`endif
  logic        IntReq;
  logic        ExcReq;
  logic [31:0] RD;
  logic [31:0] EPC;

  modport master (
    output A1, A2, WE, WD, PC_M, BD_M, ExcCode_M, EXLClr, HWInt,
`ifdef CP0_BADVADDR_EN
    output BadAddr_M,
`endif
    input  IntReq, ExcReq, RD, EPC
  );

  modport slave (
    input  A1, A2, WE, WD, PC_M, BD_M, ExcCode_M, EXLClr, HWInt,
`ifdef CP0_BADVADDR_EN
    input  BadAddr_M,
`endif
    output IntReq, ExcReq, RD, EPC
  );
endinterface

// File: rtl/cp0.sv
// System-control coprocessor 0: SR, Cause, EPC, PRId plus interrupt/exception qualification.
// Defining CP0_BADVADDR_EN adds the read-only BadVAddr register (reg 8).
module cp0
  import cp0_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  cp0_if.slave  bus
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic        int_req;
  logic        exc_req;
  logic        take;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] rd;

`ifdef CP0_BADVADDR_EN
  logic [31:0] bad_vaddr;
`endif

  // Interrupt outranks a same-cycle exception; both are masked while EXL is set.
  assign int_req = ie & ~exl & (|(bus.HWInt & im));
  assign exc_req = ~exl & (bus.ExcCode_M != EXC_INT) & ~int_req;
  assign take    = int_req | exc_req;
  assign wr_sr   = bus.WE & (bus.A2 == REG_SR);
  assign wr_epc  = bus.WE & (bus.A2 == REG_EPC);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= bus.HWInt;
      if (take) begin
        exl      <= 1'b1;
        bd       <= bus.BD_M;
        exc_code <= int_req ? EXC_INT : bus.ExcCode_M;
        epc      <= epc_of(bus.PC_M, bus.BD_M);
      end else begin
        if (wr_sr) begin
          im  <= bus.WD[15:10];
          exl <= bus.WD[1];
          ie  <= bus.WD[0];
        end else if (bus.EXLClr) begin
          exl <= 1'b0;
        end
        if (wr_epc) begin
          epc <= bus.WD;
        end
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bad_vaddr <= '0;
    end else if (exc_req && (bus.ExcCode_M == EXC_ADEL || bus.ExcCode_M == EXC_ADES)) begin
      bad_vaddr <= bus.BadAddr_M;
    end
  end
`endif

  assign sr_val    = {16'b0, im, 8'b0, exl, ie};
  assign cause_val = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

  // Reads see register state before this edge, so a same-cycle write returns the old value.
  always_comb begin
    rd = '0;
    case (bus.A1)
      REG_SR:       rd = sr_val;
      REG_CAUSE:    rd = cause_val;
      REG_EPC:      rd = epc;
      REG_PRID:     rd = PRID;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: rd = bad_vaddr;
`endif
      default:      rd = '0;
    endcase
  end

  assign bus.IntReq = int_req;
  assign bus.ExcReq = exc_req;
  assign bus.RD     = rd;
  assign bus.EPC    = epc;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed vector table followed by randomized traffic
// checked against a word-level reference model of SR/Cause/EPC/BadVAddr.
module tb_cp0;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  cp0_if bus ();

  cp0 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        we;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  code;
    logic        clr;
    logic [5:0]  hw;
    logic [31:0] badaddr;
    logic        e_int;
    logic        e_exc;
    logic [31:0] e_rd;
    logic [31:0] e_epc;
  } vec_t;

  vec_t tbl[20];

  // Reference model state, kept as full architectural words.
  logic [31:0] m_sr, m_cause, m_epc, m_bva;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst_n, input logic [4:0] a1, input logic [4:0] a2,
                              input logic we, input logic [31:0] wd, input logic [31:0] pc,
                              input logic bd, input logic [4:0] code, input logic clr,
                              input logic [5:0] hw, input logic [31:0] badaddr,
                              input logic e_int, input logic e_exc,
                              input logic [31:0] e_rd, input logic [31:0] e_epc);
    vec_t v;
    v.rst_n = rst_n; v.a1 = a1; v.a2 = a2; v.we = we; v.wd = wd; v.pc = pc; v.bd = bd;
    v.code = code; v.clr = clr; v.hw = hw; v.badaddr = badaddr;
    v.e_int = e_int; v.e_exc = e_exc; v.e_rd = e_rd; v.e_epc = e_epc;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset_n       = v.rst_n;
    bus.A1        = v.a1;
    bus.A2        = v.a2;
    bus.WE        = v.we;
    bus.WD        = v.wd;
    bus.PC_M      = v.pc;
    bus.BD_M      = v.bd;
    bus.ExcCode_M = v.code;
    bus.EXLClr    = v.clr;
    bus.HWInt     = v.hw;
`ifdef CP0_BADVADDR_EN
    bus.BadAddr_M = v.badaddr;
`endif
  endtask

  function automatic logic m_int(input logic [5:0] hw);
    logic [5:0] im;
    im = m_sr[15:10];
    return m_sr[0] && !m_sr[1] && ((hw & im) != 6'd0);
  endfunction

  function automatic logic m_exc(input logic [5:0] hw, input logic [4:0] code);
    return !m_sr[1] && (code != 5'd0) && !m_int(hw);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a1);
    case (a1)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_2020;
`ifdef CP0_BADVADDR_EN
      5'd8:    return m_bva;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Apply the architectural rules for one clock edge to the model.
  task automatic m_edge(input vec_t v);
    logic i, e;
    logic [31:0] ret;
    if (!v.rst_n) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_bva = 0;
      return;
    end
    i = m_int(v.hw);
    e = m_exc(v.hw, v.code);
    m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, v.hw} << 10);
    if (i || e) begin
      m_sr = m_sr | 32'h2;
      m_cause = (m_cause & ~32'h8000_007C) | ({31'd0, v.bd} << 31)
                | ({27'd0, (i ? 5'd0 : v.code)} << 2);
      ret = v.bd ? v.pc - 4 : v.pc;
      m_epc = ret & ~32'h3;
      if (e && (v.code == 5'd4 || v.code == 5'd5)) m_bva = v.badaddr;
    end else begin
      if (v.we && v.a2 == 5'd12) m_sr = v.wd & 32'h0000_FC03;
      else if (v.clr) m_sr = m_sr & ~32'h2;
      if (v.we && v.a2 == 5'd14) m_epc = v.wd;
    end
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 6))
      0: return 5'd8;
      1: return 5'd12;
      2: return 5'd13;
      3: return 5'd14;
      4: return 5'd15;
      5: return 5'd12;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [4:0] pick_code();
    if ($urandom_range(0, 3) != 0) return 5'd0;
    case ($urandom_range(0, 4))
      0: return 5'd4;
      1: return 5'd5;
      2: return 5'd10;
      3: return 5'd12;
      default: return 5'($urandom_range(1, 31));
    endcase
  endfunction

  initial begin
    logic [31:0] bva_exp;
    vec_t v;
    n_checks = 0;
    n_errors = 0;
`ifdef CP0_BADVADDR_EN
    bva_exp = 32'h0000_0003;
`else
    bva_exp = 32'h0;
`endif
    // rst a1 a2 we wd pc bd code clr hw badaddr | int exc rd epc
    tbl[0]  = mk(1, 12, 0,  0, 0,          0,          0, 0,  0, 6'h00, 0, 0, 0, 32'h0,          32'h0);
    tbl[1]  = mk(1, 13, 0,  0, 0,          0,          0, 0,  0, 6'h00, 0, 0, 0, 32'h0,          32'h0);
    tbl[2]  = mk(1, 12, 12, 1, 32'h401,    0,          0, 0,  0, 6'h00, 0, 0, 0, 32'h0,          32'h0);
    tbl[3]  = mk(1, 12, 0,  0, 0,          32'h3000,   0, 0,  0, 6'h01, 0, 1, 0, 32'h401,        32'h0);
    tbl[4]  = mk(1, 13, 0,  0, 0,          0,          0, 0,  0, 6'h01, 0, 0, 0, 32'h400,        32'h3000);
    tbl[5]  = mk(1, 12, 0,  0, 0,          0,          0, 0,  1, 6'h00, 0, 0, 0, 32'h403,        32'h3000);
    tbl[6]  = mk(1, 12, 0,  0, 0,          32'h3010,   0, 12, 0, 6'h00, 0, 0, 1, 32'h401,        32'h3000);
    tbl[7]  = mk(1, 13, 0,  0, 0,          0,          0, 0,  1, 6'h00, 0, 0, 0, 32'h30,         32'h3010);
    tbl[8]  = mk(1, 14, 0,  0, 0,          32'h3024,   1, 4,  0, 6'h00, 3, 0, 1, 32'h3010,       32'h3010);
    tbl[9]  = mk(1, 13, 0,  0, 0,          0,          0, 0,  0, 6'h00, 0, 0, 0, 32'h8000_0010,  32'h3020);
    tbl[10] = mk(1, 8,  0,  0, 0,          32'h5000,   0, 10, 0, 6'h01, 0, 0, 0, bva_exp,        32'h3020);
    tbl[11] = mk(1, 13, 0,  0, 0,          0,          0, 0,  1, 6'h01, 0, 0, 0, 32'h8000_0410,  32'h3020);
    tbl[12] = mk(1, 12, 14, 1, 32'h1234,   32'h3040,   0, 12, 0, 6'h01, 0, 1, 0, 32'h401,        32'h3020);
    tbl[13] = mk(1, 13, 0,  0, 0,          0,          0, 0,  0, 6'h00, 0, 0, 0, 32'h400,        32'h3040);
    tbl[14] = mk(1, 14, 0,  0, 0,          0,          0, 0,  0, 6'h00, 0, 0, 0, 32'h3040,       32'h3040);
    tbl[15] = mk(1, 15, 0,  0, 0,          0,          0, 0,  0, 6'h00, 0, 0, 0, 32'h2020,       32'h3040);
    tbl[16] = mk(1, 20, 0,  0, 0,          0,          0, 0,  0, 6'h00, 0, 0, 0, 32'h0,          32'h3040);
    tbl[17] = mk(0, 12, 0,  0, 0,          0,          0, 0,  0, 6'h00, 0, 0, 0, 32'h403,        32'h3040);
    tbl[18] = mk(1, 12, 0,  0, 0,          0,          0, 0,  0, 6'h00, 0, 0, 0, 32'h0,          32'h0);
    tbl[19] = mk(1, 14, 0,  0, 0,          0,          0, 0,  0, 6'h3F, 0, 0, 0, 32'h0,          32'h0);

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 20; k++) begin
      drive(tbl[k]);
      @(negedge clk);
      chk($sformatf("vec%0d_intreq", k), {31'd0, bus.IntReq}, {31'd0, tbl[k].e_int});
      chk($sformatf("vec%0d_excreq", k), {31'd0, bus.ExcReq}, {31'd0, tbl[k].e_exc});
      chk($sformatf("vec%0d_rd", k),     bus.RD,  tbl[k].e_rd);
      chk($sformatf("vec%0d_epc", k),    bus.EPC, tbl[k].e_epc);
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the model, starting from a fresh reset.
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    m_edge(v);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3000; k++) begin
      v.rst_n   = ($urandom_range(0, 99) != 0);
      v.a1      = pick_reg();
      v.a2      = pick_reg();
      v.we      = ($urandom_range(0, 3) == 0);
      v.wd      = $urandom;
      v.pc      = $urandom;
      v.bd      = 1'($urandom_range(0, 1));
      v.code    = pick_code();
      v.clr     = ($urandom_range(0, 3) == 0);
      v.hw      = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      v.badaddr = $urandom;
      drive(v);
      @(negedge clk);
      chk("rand_intreq", {31'd0, bus.IntReq}, {31'd0, m_int(v.hw)});
      chk("rand_excreq", {31'd0, bus.ExcReq}, {31'd0, m_exc(v.hw, v.code)});
      chk("rand_rd",     bus.RD,  m_rd(v.a1));
      chk("rand_epc",    bus.EPC, m_epc);
      m_edge(v);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
